decode_fetch_queue: RTL and testbench
=====================================

# decode_fetch_queue

Parametrised multi-lane instruction queue between fetch and the decode unit. It accepts up to `fetchWidth` instructions per cycle, assigns each one a sequential major ID, buffers them in a circular queue, and presents up to `decodeWidth` instructions per cycle to decode under a stall handshake. It replaces the single-instruction, externally-numbered decode input path with a wider, buffered, flushable front end.

## Interface
- `addressWidth`, 64, instruction address width
- `instructionWidth`, 32, instruction word width
- `PidSize`, 20, process ID width
- `TidSize`, 16, thread ID width
- `instructionCounterWidth`, 64, major ID width
- `fetchWidth`, 2, input lanes
- `decodeWidth`, 2, output lanes
- `queueDepth`, 8, entries; power of two, ≥ 2*fetchWidth and ≥ decodeWidth
- `countWidth`, $clog2(queueDepth+1), occupancy counter width

Ports:
- `clock_i`  in  1  single clock; all state updates on rising edge
- `reset_i`  in  1  reset, synchronous, active-high
- `enable_i`  in  1  input bundle valid
- `stall_i`  in  1  decode cannot accept; no pop this edge
- `flush_i`  in  1  discard all entries
- `flushMajId_i`  in  instructionCounterWidth  major ID given to the first instruction after a flush
- `instCount_i`  in  $clog2(fetchWidth+1)  valid lanes, contiguous from lane 0
- `instructions_i`  in  fetchWidth*instructionWidth  lane k at bits [k*instructionWidth +: instructionWidth]
- `address_i`  in  addressWidth  lane 0 address; lane k = address_i + 4k
- `is64Bit_i`, `pid_i`, `tid_i`  in  1 / PidSize / TidSize  shared by all lanes of the bundle
- `ready_o`  out  1  free entries ≥ fetchWidth
- `enable_o`  out  1  outCount_o > 0
- `outCount_o`  out  $clog2(decodeWidth+1)  valid output lanes
- `instructions_o`, `addresses_o`, `majIds_o`  out  decodeWidth × field width  per-lane, same packing as input
- `is64Bit_o`, `pids_o`, `tids_o`  out  decodeWidth × field width  per-lane copies of stored bundle fields
- `overflow_o`  out  1  sticky: push attempted while ready_o = 0

## Operation
- State: storage array, head and tail pointers (mod queueDepth), `count`, `majIdCtr`, `overflow`.
- pushN = min(instCount_i, fetchWidth) when enable_i & ready_o & !flush_i, else 0. instCount_i > fetchWidth is illegal and clamped.
- Pushed lane k is stored at tail+k with majId = majIdCtr + k (mod 2^instructionCounterWidth); majIdCtr += pushN; tail += pushN.
- outCount_o = min(count, decodeWidth); output lane k shows entry head+k; lanes k ≥ outCount_o are driven to all zeros.
- popN = outCount_o when !stall_i & !flush_i, else 0; head += popN.
- count_next = count + pushN − popN. Simultaneous push and pop are legal at any occupancy.
- ready_o = (queueDepth − count) ≥ fetchWidth, a function of registered count only (conservative; pops in the same cycle do not raise it).
- enable_i & !ready_o & !flush_i: bundle ignored, majIdCtr unchanged, overflow set; it clears only on reset.
- flush_i overrides push and pop: head = tail = count = 0, majIdCtr = flushMajId_i. overflow is unaffected.
- reset_i overrides everything: count, pointers, majIdCtr, overflow = 0. Storage contents need not be cleared but must not be visible.

## Timing
- Reset values: ready_o = 1; enable_o, outCount_o, overflow_o = 0; all data outputs 0.
- Outputs are combinational from registered state (head, count, storage). An instruction pushed at edge t is visible on the outputs in the cycle after edge t, giving 1-cycle latency.
- Decode samples the outputs on the edge where stall_i = 0; those entries are removed at that edge.
- While stall_i = 1, outputs hold steady except that outCount_o may grow as pushes arrive.
- Pointer wrap is silent and ordering is preserved across the wrap.

## Test plan
- Reset, then push instCount_i = 2 with address_i = 0x1000, stall_i = 0 -> next cycle enable_o = 1, outCount_o = 2, addresses 0x1000/0x1004, majIds 0/1; after the following edge enable_o = 0.
- stall_i = 1, push 2 per cycle -> ready_o = 1 at count = 6 and 0 at count = 8. A 5th push is ignored and overflow_o = 1; after draining, the next push gets majId 8.
- 30 cycles of random instCount_i (0–2) and random stall_i -> the output stream is in order, majIds are contiguous, there is no loss or duplication across pointer wrap, and count never exceeds 8.
- count = 5, flush_i = 1 with enable_i = 1 and flushMajId_i = 0x100 -> next cycle enable_o = 0 and ready_o = 1; the next push gets majIds 0x100 and 0x101.
- count = 2, push 2 and pop 2 on the same edge -> count stays 2 and the new pair appears next cycle. Push instCount_i = 1 into an empty queue -> outCount_o = 1 and lane 1 outputs are all zero.
- Reset asserted with count = 6 and overflow_o = 1 -> after that edge all outputs are at reset values and ready_o = 1.

Source files
------------

// File: rtl/decode_fetch_queue.sv
// ---------------------------------------------------------------------------
// decode_fetch_queue
//
// Multi-lane instruction queue between fetch and decode. Each cycle it accepts
// up to fetchWidth instructions and gives each one a sequential major ID. The
// instructions are held in a circular buffer, and up to decodeWidth of them
// are presented to decode under a stall handshake. A flush empties the queue
// and restarts major-ID numbering from flushMajId_i.
//
// Ports
//   clock_i, reset_i     clock; synchronous active-high reset
//   enable_i             input bundle valid
//   stall_i              decode cannot accept this cycle (no pop)
//   flush_i              discard all entries, reload the major-ID counter
//   flushMajId_i         major ID of the first instruction after a flush
//   instCount_i          valid input lanes, contiguous from lane 0
//   instructions_i       lane k at [k*instructionWidth +: instructionWidth]
//   address_i            lane 0 address; lane k sits at address_i + 4k
//   is64Bit_i/pid_i/tid_i  bundle-wide attributes copied into every entry
//   ready_o              at least fetchWidth free entries
//   enable_o, outCount_o valid output lanes (contiguous from lane 0)
//   instructions_o, addresses_o, majIds_o, is64Bit_o, pids_o, tids_o
//                        per-lane output fields; unused lanes read as zero
//   overflow_o           sticky: a push arrived while ready_o was low
// ---------------------------------------------------------------------------
module decode_fetch_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int fetchWidth              = 2,
  parameter int decodeWidth             = 2,
  parameter int queueDepth              = 8,
  parameter int countWidth              = $clog2(queueDepth + 1)
) (
  input  logic                                    clock_i,
  input  logic                                    reset_i,
  input  logic                                    enable_i,
  input  logic                                    stall_i,
  input  logic                                    flush_i,
  input  logic [instructionCounterWidth-1:0]      flushMajId_i,
  input  logic [$clog2(fetchWidth+1)-1:0]         instCount_i,
  input  logic [fetchWidth*instructionWidth-1:0]  instructions_i,
  input  logic [addressWidth-1:0]                 address_i,
  input  logic                                    is64Bit_i,
  input  logic [PidSize-1:0]                      pid_i,
  input  logic [TidSize-1:0]                      tid_i,
  output logic                                    ready_o,
  output logic                                    enable_o,
  output logic [$clog2(decodeWidth+1)-1:0]        outCount_o,
  output logic [decodeWidth*instructionWidth-1:0] instructions_o,
  output logic [decodeWidth*addressWidth-1:0]     addresses_o,
  output logic [decodeWidth*instructionCounterWidth-1:0] majIds_o,
  output logic [decodeWidth-1:0]                  is64Bit_o,
  output logic [decodeWidth*PidSize-1:0]          pids_o,
  output logic [decodeWidth*TidSize-1:0]          tids_o,
  output logic                                    overflow_o
);

  localparam int ptrWidth      = $clog2(queueDepth);
  localparam int inCountWidth  = $clog2(fetchWidth + 1);
  localparam int outCountWidth = $clog2(decodeWidth + 1);

  typedef struct packed {
    logic [instructionWidth-1:0]        instruction;
    logic [addressWidth-1:0]            address;
    logic [instructionCounterWidth-1:0] majId;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
  } entryT;

  entryT                              storage [queueDepth];
  logic [ptrWidth-1:0]                head;
  logic [ptrWidth-1:0]                tail;
  logic [countWidth-1:0]              count;
  logic [instructionCounterWidth-1:0] majIdCtr;
  logic                               overflow;

  logic                               ready;
  logic [inCountWidth-1:0]            laneCount;
  logic [countWidth-1:0]              pushN;
  logic [outCountWidth-1:0]           outCount;
  logic [outCountWidth-1:0]           popN;

  // ready depends on the registered count only. A pop on the same edge does
  // not count toward it, so this can refuse a bundle that would have fit.
  assign ready     = (count <= countWidth'(queueDepth - fetchWidth));
  // An out-of-range lane count is clamped instead of corrupting the pointers.
  assign laneCount = (instCount_i > inCountWidth'(fetchWidth)) ?
                     inCountWidth'(fetchWidth) : instCount_i;
  assign pushN     = (enable_i && ready && !flush_i) ? countWidth'(laneCount) : '0;
  assign outCount  = (count < countWidth'(decodeWidth)) ?
                     outCountWidth'(count) : outCountWidth'(decodeWidth);
  assign popN      = (!stall_i && !flush_i) ? outCount : '0;

  // Control state. Reset takes priority over flush, and flush over push/pop.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every reader
    // in this edge sees the pre-edge values regardless of block ordering.
    if (reset_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      majIdCtr <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      majIdCtr <= flushMajId_i;
    end else begin
      head     <= head + ptrWidth'(popN);
      tail     <= tail + ptrWidth'(pushN);
      count    <= count + pushN - countWidth'(popN);
      majIdCtr <= majIdCtr + instructionCounterWidth'(pushN);
      if (enable_i && !ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage. The pointer arithmetic wraps naturally modulo queueDepth.
  // NOTE: the array has no reset. count gates every read, so stale contents
  // never reach the outputs, and the array can map onto plain RAM/flops.
  always_ff @(posedge clock_i) begin
    for (int k = 0; k < fetchWidth; k++) begin
      if (countWidth'(k) < pushN) begin
        storage[tail + ptrWidth'(k)] <= '{
          instruction: instructions_i[k*instructionWidth +: instructionWidth],
          address:     address_i + addressWidth'(4 * k),
          majId:       majIdCtr + instructionCounterWidth'(k),
          is64Bit:     is64Bit_i,
          pid:         pid_i,
          tid:         tid_i
        };
      end
    end
  end

  // Output lanes read straight from registered state.
  always_comb begin
    // NOTE: every output gets a default before the loop. Lanes past outCount
    // then read as zero, and no path through the block infers a latch.
    instructions_o = '0;
    addresses_o    = '0;
    majIds_o       = '0;
    is64Bit_o      = '0;
    pids_o         = '0;
    tids_o         = '0;
    for (int k = 0; k < decodeWidth; k++) begin
      if (outCountWidth'(k) < outCount) begin
        instructions_o[k*instructionWidth +: instructionWidth] =
          storage[head + ptrWidth'(k)].instruction;
        addresses_o[k*addressWidth +: addressWidth] =
          storage[head + ptrWidth'(k)].address;
        majIds_o[k*instructionCounterWidth +: instructionCounterWidth] =
          storage[head + ptrWidth'(k)].majId;
        is64Bit_o[k] = storage[head + ptrWidth'(k)].is64Bit;
        pids_o[k*PidSize +: PidSize] = storage[head + ptrWidth'(k)].pid;
        tids_o[k*TidSize +: TidSize] = storage[head + ptrWidth'(k)].tid;
      end
    end
  end

  assign ready_o    = ready;
  assign enable_o   = (outCount != '0);
  assign outCount_o = outCount;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_decode_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_fetch_queue
//
// Directed bench for decode_fetch_queue with the default parameters
// (fetchWidth = decodeWidth = 2, queueDepth = 8). Fixed sequences check
// against hand-computed values. A short random phase checks against a small
// queue model.
// ---------------------------------------------------------------------------
module tb_decode_fetch_queue;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int PW = 20;
  localparam int TW = 16;
  localparam int CW = 64;
  localparam int FW = 2;
  localparam int DW = 2;
  localparam int QD = 8;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic              stall_i;
  logic              flush_i;
  logic [CW-1:0]     flushMajId_i;
  logic [1:0]        instCount_i;
  logic [FW*IW-1:0]  instructions_i;
  logic [AW-1:0]     address_i;
  logic              is64Bit_i;
  logic [PW-1:0]     pid_i;
  logic [TW-1:0]     tid_i;
  logic              ready_o;
  logic              enable_o;
  logic [1:0]        outCount_o;
  logic [DW*IW-1:0]  instructions_o;
  logic [DW*AW-1:0]  addresses_o;
  logic [DW*CW-1:0]  majIds_o;
  logic [DW-1:0]     is64Bit_o;
  logic [DW*PW-1:0]  pids_o;
  logic [DW*TW-1:0]  tids_o;
  logic              overflow_o;

  decode_fetch_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .stall_i(stall_i), .flush_i(flush_i), .flushMajId_i(flushMajId_i),
    .instCount_i(instCount_i), .instructions_i(instructions_i),
    .address_i(address_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i),
    .tid_i(tid_i), .ready_o(ready_o), .enable_o(enable_o),
    .outCount_o(outCount_o), .instructions_o(instructions_o),
    .addresses_o(addresses_o), .majIds_o(majIds_o), .is64Bit_o(is64Bit_o),
    .pids_o(pids_o), .tids_o(tids_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [63:0] majId;
    logic [63:0] addr;
  } expT;

  expT         modelQ[$];
  logic [63:0] modelCtr;

  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] instrFor(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic setBundle(input logic en, input int cnt, input logic [63:0] addr);
    enable_i       = en;
    instCount_i    = 2'(cnt);
    address_i      = addr;
    instructions_i = {instrFor(addr + 64'd4), instrFor(addr)};
  endtask

  task automatic checkLane(input string tag, input int k,
                           input logic [63:0] majId, input logic [63:0] addr);
    checkValue($sformatf("%s_maj%0d", tag, k), majIds_o[k*CW +: CW], majId);
    checkValue($sformatf("%s_addr%0d", tag, k), addresses_o[k*AW +: AW], addr);
    checkValue($sformatf("%s_inst%0d", tag, k),
               64'(instructions_o[k*IW +: IW]), 64'(instrFor(addr)));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "_ready"}, 64'(ready_o), 64'd1);
    checkValue({tag, "_enable"}, 64'(enable_o), 64'd0);
    checkValue({tag, "_outCount"}, 64'(outCount_o), 64'd0);
    checkValue({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    checkValue({tag, "_majIds"}, 64'(|majIds_o), 64'd0);
    checkValue({tag, "_addrs"}, 64'(|addresses_o), 64'd0);
    checkValue({tag, "_insts"}, 64'(|instructions_o), 64'd0);
    checkValue({tag, "_attrs"}, 64'(|{is64Bit_o, pids_o, tids_o}), 64'd0);
  endtask

  // Compare the DUT outputs with the head of the model queue.
  task automatic checkModel(input string tag);
    int expCount;
    expCount = (modelQ.size() < DW) ? modelQ.size() : DW;
    checkValue({tag, "_outCount"}, 64'(outCount_o), 64'(expCount));
    checkValue({tag, "_ready"}, 64'(ready_o), 64'((QD - modelQ.size()) >= FW));
    for (int k = 0; k < DW; k++) begin
      if (k < expCount) begin
        checkLane(tag, k, modelQ[k].majId, modelQ[k].addr);
      end else begin
        checkValue($sformatf("%s_idle%0d", tag, k), majIds_o[k*CW +: CW], 64'd0);
      end
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    flushMajId_i = '0;
    is64Bit_i    = 1'b1;
    pid_i        = 20'hABCDE;
    tid_i        = 16'h1234;
    setBundle(1'b0, 0, 64'h0);
    tick();
    tick();
    checkResetOutputs("reset");
    reset_i = 1'b0;

    // A two-lane push is visible after one edge, then popped.
    setBundle(1'b1, 2, 64'h1000);
    tick();
    setBundle(1'b0, 0, 64'h0);
    checkValue("t1_enable", 64'(enable_o), 64'd1);
    checkValue("t1_outCount", 64'(outCount_o), 64'd2);
    checkLane("t1", 0, 64'd0, 64'h1000);
    checkLane("t1", 1, 64'd1, 64'h1004);
    checkValue("t1_pid", 64'(pids_o[PW-1:0]), 64'hABCDE);
    checkValue("t1_tid1", 64'(tids_o[2*TW-1:TW]), 64'h1234);
    checkValue("t1_is64", 64'(is64Bit_o), 64'h3);
    tick();
    checkValue("t1_popped", 64'(enable_o), 64'd0);

    // Fill under stall, overflow, drain in order.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    stall_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      setBundle(1'b1, 2, 64'h1000 + 64'(16 * b));
      tick();
      if (b == 2) checkValue("t2_ready6", 64'(ready_o), 64'd1);
    end
    checkValue("t2_ready8", 64'(ready_o), 64'd0);
    checkValue("t2_noovf", 64'(overflow_o), 64'd0);
    setBundle(1'b1, 2, 64'h9000);
    tick();
    checkValue("t2_overflow", 64'(overflow_o), 64'd1);
    checkLane("t2_hold", 0, 64'd0, 64'h1000);
    setBundle(1'b0, 0, 64'h0);
    stall_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checkLane($sformatf("t2_drain%0d", b), 0, 64'(2 * b), 64'h1000 + 64'(16 * b));
      checkLane($sformatf("t2_drain%0d", b), 1, 64'(2 * b + 1), 64'h1004 + 64'(16 * b));
      tick();
    end
    checkValue("t2_empty", 64'(enable_o), 64'd0);
    setBundle(1'b1, 1, 64'h1100);
    tick();
    setBundle(1'b0, 0, 64'h0);
    checkValue("t2_after_outCount", 64'(outCount_o), 64'd1);
    checkLane("t2_after", 0, 64'd8, 64'h1100);
    tick();
    modelCtr = 64'd9;

    // Random push/stall mix against the queue model, then drain.
    for (int c = 0; c < 30; c++) begin
      int  cnt;
      int  nPop;
      logic st;
      logic modelReady;
      logic [63:0] addr;
      checkModel($sformatf("rand%0d", c));
      cnt  = int'($urandom_range(0, 2));
      st   = 1'($urandom_range(0, 1));
      addr = 64'h2000 + 64'(16 * c);
      setBundle(1'b1, cnt, addr);
      stall_i    = st;
      modelReady = (QD - modelQ.size()) >= FW;
      nPop       = st ? 0 : ((modelQ.size() < DW) ? modelQ.size() : DW);
      for (int p = 0; p < nPop; p++) void'(modelQ.pop_front());
      if (modelReady) begin
        for (int k = 0; k < cnt; k++) begin
          modelQ.push_back('{majId: modelCtr + 64'(k), addr: addr + 64'(4 * k)});
        end
        modelCtr = modelCtr + 64'(cnt);
      end
      tick();
    end
    setBundle(1'b0, 0, 64'h0);
    stall_i = 1'b0;
    for (int g = 0; g < 8 && modelQ.size() > 0; g++) begin
      int nPop;
      checkModel($sformatf("drain%0d", g));
      nPop = (modelQ.size() < DW) ? modelQ.size() : DW;
      for (int p = 0; p < nPop; p++) void'(modelQ.pop_front());
      tick();
    end
    checkValue("rand_drained", 64'(enable_o), 64'd0);

    // Flush with five entries held and a push offered on the same edge.
    stall_i = 1'b1;
    setBundle(1'b1, 2, 64'h3000); tick();
    setBundle(1'b1, 2, 64'h3010); tick();
    setBundle(1'b1, 1, 64'h3020); tick();
    checkLane("t4_pre", 0, modelCtr, 64'h3000);
    flush_i      = 1'b1;
    flushMajId_i = 64'h100;
    stall_i      = 1'b0;
    setBundle(1'b1, 2, 64'h3030);
    tick();
    flush_i = 1'b0;
    checkValue("t4_enable", 64'(enable_o), 64'd0);
    checkValue("t4_ready", 64'(ready_o), 64'd1);
    checkValue("t4_overflow_kept", 64'(overflow_o), 64'd1);
    stall_i = 1'b1;
    setBundle(1'b1, 2, 64'h3100);
    tick();
    checkLane("t4_post", 0, 64'h100, 64'h3100);
    checkLane("t4_post", 1, 64'h101, 64'h3104);

    // Push and pop two on the same edge with count = 2.
    stall_i = 1'b0;
    setBundle(1'b1, 2, 64'h4000);
    tick();
    checkValue("t5_outCount", 64'(outCount_o), 64'd2);
    checkLane("t5", 0, 64'h102, 64'h4000);
    checkLane("t5", 1, 64'h103, 64'h4004);
    setBundle(1'b0, 0, 64'h0);
    tick();
    checkValue("t5_empty", 64'(enable_o), 64'd0);
    stall_i = 1'b1;
    setBundle(1'b1, 1, 64'h5000);
    tick();
    checkValue("t5_single_count", 64'(outCount_o), 64'd1);
    checkLane("t5_single", 0, 64'h104, 64'h5000);
    checkValue("t5_lane1_maj", majIds_o[2*CW-1:CW], 64'd0);
    checkValue("t5_lane1_addr", addresses_o[2*AW-1:AW], 64'd0);
    checkValue("t5_lane1_inst", 64'(instructions_o[2*IW-1:IW]), 64'd0);
    checkValue("t5_lane1_attr", 64'({is64Bit_o[1], pids_o[2*PW-1:PW], tids_o[2*TW-1:TW]}), 64'd0);

    // Reset with six entries held and overflow set.
    setBundle(1'b1, 2, 64'h6000); tick();
    setBundle(1'b1, 2, 64'h6010); tick();
    setBundle(1'b1, 1, 64'h6020); tick();
    setBundle(1'b0, 0, 64'h0);
    checkValue("t6_pre_overflow", 64'(overflow_o), 64'd1);
    checkValue("t6_pre_outCount", 64'(outCount_o), 64'd2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkResetOutputs("t6_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
